// File: rtl/wb_sdram_arbiter.sv
// Two-requester Wishbone arbiter in front of the SDRAM controller slave port.
// Round-robin on contention; a grant is held for the whole Wishbone cycle.
module wb_sdram_arbiter #(
    parameter int dw     = 32,
    parameter int APP_AW = 26
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [APP_AW-1:0] m0_addr_i,
    input  logic [dw-1:0]     m0_dat_i,
    input  logic [dw/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic              m0_ack_o,
    output logic [dw-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [APP_AW-1:0] m1_addr_i,
    input  logic [dw-1:0]     m1_dat_i,
    input  logic [dw/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic              m1_ack_o,
    output logic [dw-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [APP_AW-1:0] s_addr_o,
    output logic [dw-1:0]     s_dat_o,
    output logic [dw/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic              s_ack_i,
    input  logic [dw-1:0]     s_dat_i,

    output logic [1:0]        gnt_o
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   prio_q, prio_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (sdr_init_done) begin
                    if (m0_cyc_i && (!m1_cyc_i || !prio_q))
                        state_d = GNT0;
                    else if (m1_cyc_i)
                        state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    prio_d  = 1'b1;
                    state_d = (m1_cyc_i && sdr_init_done) ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    prio_d  = 1'b0;
                    state_d = (m0_cyc_i && sdr_init_done) ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    assign gnt_o    = state_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
